// File: rtl/bimodal_predictor_pkg.sv
// Shared types, constants and helper functions for the bimodal branch predictor.
// The hash and counter helpers take their widths as arguments so any instance can use them.
package bimodal_predictor_pkg;

    localparam int CTR_WIDTH_DEF = 2;
    localparam logic [CTR_WIDTH_DEF-1:0] WEAK_NT = 2'b01;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Widest index / counter the helpers support.
    localparam int MAX_IDX_W = 32;
    localparam int HASH_W    = 2 * MAX_IDX_W + 2;
    localparam int MAX_CTR_W = 8;

    typedef logic [HASH_W-1:0]    hash_t;
    typedef logic [MAX_CTR_W-1:0] ctr_t;

    // index = pc[idx_w+1:2] ^ pc[2*idx_w+1:idx_w+2]
    function automatic logic [MAX_IDX_W-1:0] index_hash(input hash_t pc, input int idx_w);
        hash_t lo;
        hash_t hi;
        hash_t mask;
        hash_t res;
        lo   = pc >> 2;
        hi   = pc >> (idx_w + 2);
        mask = (hash_t'(1) << idx_w) - hash_t'(1);
        res  = (lo ^ hi) & mask;
        return res[MAX_IDX_W-1:0];
    endfunction

    // Saturating increment when taken, saturating decrement otherwise.
    function automatic ctr_t sat_step(input ctr_t base, input logic taken, input int ctr_w);
        ctr_t top;
        top = (ctr_t'(1) << ctr_w) - ctr_t'(1);
        if (taken) begin
            return (base >= top) ? top : base + ctr_t'(1);
        end
        return (base == '0) ? '0 : base - ctr_t'(1);
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic ctr_t weak_nt(input int ctr_w);
        return (ctr_t'(1) << (ctr_w - 1)) - ctr_t'(1);
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module dual_port_ram #(
    parameter int data_width  = 2,
    parameter int num_entries = 512,
    localparam int ADDR_W     = $clog2(num_entries)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [num_entries];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: hashed table of saturating counters with an init sweep,
// one-cycle prediction reads, same-cycle update writes and a last-write forwarding register.
module bimodal_predictor
    import bimodal_predictor_pkg::*;
#(
    parameter int NUM_ENTRIES = 512,
    parameter int CTR_WIDTH   = CTR_WIDTH_DEF,
    parameter int PC_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    output logic                 pred_ready,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_resp_valid,
    output logic                 pred_taken,
    output logic [CTR_WIDTH-1:0] pred_ctr,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [CTR_WIDTH-1:0] upd_ctr,
    output logic                 init_busy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [CTR_WIDTH-1:0] INIT_VAL = CTR_WIDTH'(weak_nt(CTR_WIDTH));

    bp_state_e        state_reg, state_next;
    logic [IDX_W-1:0] sweep_reg, sweep_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_INIT;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        case (state_reg)
            ST_INIT: begin
                sweep_next = sweep_reg + 1'b1;
                if (sweep_reg == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Ready is also masked by rst so nothing is accepted in a reset cycle.
    assign init_busy  = (state_reg == ST_INIT);
    assign pred_ready = (state_reg == ST_RUN) && !rst;
    assign upd_ready  = (state_reg == ST_RUN) && !rst;

    logic pred_fire;
    logic upd_fire;
    assign pred_fire = pred_valid && pred_ready;
    assign upd_fire  = upd_valid && upd_ready;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    assign pred_idx = IDX_W'(index_hash(hash_t'(pred_pc), IDX_W));
    assign upd_idx  = IDX_W'(index_hash(hash_t'(upd_pc), IDX_W));

    // Last-write register: the caller's snapshot may predate our own most recent write.
    logic                 lw_valid_reg;
    logic [IDX_W-1:0]     lw_idx_reg;
    logic [CTR_WIDTH-1:0] lw_val_reg;
    logic [CTR_WIDTH-1:0] upd_base;
    logic [CTR_WIDTH-1:0] upd_new;

    assign upd_base = (lw_valid_reg && (lw_idx_reg == upd_idx)) ? lw_val_reg : upd_ctr;
    assign upd_new  = CTR_WIDTH'(sat_step(ctr_t'(upd_base), upd_taken, CTR_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            lw_valid_reg <= 1'b0;
            lw_idx_reg   <= '0;
            lw_val_reg   <= '0;
        end else if (upd_fire) begin
            lw_valid_reg <= 1'b1;
            lw_idx_reg   <= upd_idx;
            lw_val_reg   <= upd_new;
        end
    end

    logic                 ram_we;
    logic [IDX_W-1:0]     ram_waddr;
    logic [CTR_WIDTH-1:0] ram_wdata;
    logic [CTR_WIDTH-1:0] ram_rdata;

    assign ram_we    = init_busy || upd_fire;
    assign ram_waddr = init_busy ? sweep_reg : upd_idx;
    assign ram_wdata = init_busy ? INIT_VAL : upd_new;

    dual_port_ram #(
        .data_width (CTR_WIDTH),
        .num_entries(NUM_ENTRIES)
    ) u_table (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (pred_fire),
        .raddr(pred_idx),
        .rdata(ram_rdata)
    );

    // The RAM returns the old value on a same-address collision, so forward the new one.
    logic                 resp_valid_reg;
    logic                 bypass_reg;
    logic [CTR_WIDTH-1:0] bypass_val_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            bypass_reg     <= 1'b0;
            bypass_val_reg <= '0;
        end else begin
            resp_valid_reg <= pred_fire;
            bypass_reg     <= pred_fire && upd_fire && (upd_idx == pred_idx);
            bypass_val_reg <= upd_new;
        end
    end

    assign pred_resp_valid = resp_valid_reg;
    assign pred_ctr        = resp_valid_reg ? (bypass_reg ? bypass_val_reg : ram_rdata) : '0;
    assign pred_taken      = pred_ctr[CTR_WIDTH-1];

endmodule

// File: tb/tb_bimodal_predictor.sv
// Self-checking bench for bimodal_predictor: table-driven RUN vectors with a response
// scoreboard, plus hand-written reset/init sequences.
module tb_bimodal_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_ctr;
    logic        init_busy;

    always #5 clk = ~clk;

    bimodal_predictor #(
        .NUM_ENTRIES(512),
        .CTR_WIDTH  (2),
        .PC_WIDTH   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_pc        (pred_pc),
        .pred_resp_valid(pred_resp_valid),
        .pred_taken     (pred_taken),
        .pred_ctr       (pred_ctr),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_ctr        (upd_ctr),
        .init_busy      (init_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [1:0]  uc;
        logic [1:0]  exp_ctr;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic pv, input logic [31:0] ppc, input logic uv,
                                input logic [31:0] upc, input logic ut, input logic [1:0] uc,
                                input logic [1:0] exp_ctr);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ut = ut; v.uc = uc;
        v.exp_ctr = exp_ctr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive, let the edge happen, then score the response window.
    task automatic cycle(input logic r, input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [1:0] uc,
                         input logic [1:0] exp_ctr);
        logic       acc;
        logic [1:0] e;
        rst = r; pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_ctr = uc;
        #1;
        acc = pv && pred_ready && !r;
        if (acc) exp_q.push_back(exp_ctr);
        @(posedge clk);
        #1;
        check("resp_valid", {31'b0, pred_resp_valid}, {31'b0, acc});
        if (pred_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pred_ctr", {30'b0, pred_ctr}, {30'b0, e});
                check("pred_taken", {31'b0, pred_taken}, {31'b0, e[1]});
            end
        end
        $display("cyc rst=%0b pv=%0b ppc=%h uv=%0b upc=%h ut=%0b uc=%0d -> rv=%0b ctr=%0d busy=%0b",
                 r, pv, ppc, uv, upc, ut, uc, pred_resp_valid, pred_ctr, init_busy);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, init_busy}, 32'd1);
        check({tag, "_pred_ready"}, {31'b0, pred_ready}, 32'd0);
        check({tag, "_upd_ready"}, {31'b0, upd_ready}, 32'd0);
        check({tag, "_pred_ctr"}, {30'b0, pred_ctr}, 32'd0);
        check({tag, "_pred_taken"}, {31'b0, pred_taken}, 32'd0);
    endtask

    // Counts busy cycles after a reset cycle (inclusive of the cycle after it), bounded.
    task automatic measure_init(input string tag);
        int cnt;
        cnt = 1;
        for (int i = 0; i < 2000 && init_busy; i++) begin
            idle();
            if (init_busy) cnt++;
        end
        check({tag, "_init_cycles"}, cnt, 32'd512);
        check({tag, "_ready_after"}, {30'b0, pred_ready, upd_ready}, 32'd3);
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_ctr = '0;

        // Hand-derived: 0x1000->idx2, 0x2000->4, 0x3000->6, 0x4000->8,
        // 0x0004->1, 0x0800->1, 0x0804->0.
        vecs[0]  = mk(1, 32'h1000, 0, 32'h0,    0, 2'd0, 2'd1);
        vecs[1]  = mk(0, 32'h0,    1, 32'h2000, 1, 2'd3, 2'd0);
        vecs[2]  = mk(0, 32'h0,    1, 32'h2000, 1, 2'd3, 2'd0);
        vecs[3]  = mk(0, 32'h0,    1, 32'h2000, 1, 2'd3, 2'd0);
        vecs[4]  = mk(0, 32'h0,    1, 32'h2000, 1, 2'd3, 2'd0);
        vecs[5]  = mk(1, 32'h2000, 0, 32'h0,    0, 2'd0, 2'd3);
        vecs[6]  = mk(0, 32'h0,    1, 32'h2000, 0, 2'd0, 2'd0);
        vecs[7]  = mk(0, 32'h0,    1, 32'h2000, 0, 2'd0, 2'd0);
        vecs[8]  = mk(0, 32'h0,    1, 32'h2000, 0, 2'd0, 2'd0);
        vecs[9]  = mk(0, 32'h0,    1, 32'h2000, 0, 2'd0, 2'd0);
        vecs[10] = mk(1, 32'h2000, 0, 32'h0,    0, 2'd0, 2'd0);
        vecs[11] = mk(0, 32'h0,    1, 32'h3000, 1, 2'd1, 2'd0);
        vecs[12] = mk(0, 32'h0,    1, 32'h3000, 1, 2'd1, 2'd0);
        vecs[13] = mk(1, 32'h3000, 0, 32'h0,    0, 2'd0, 2'd3);
        vecs[14] = mk(1, 32'h4000, 1, 32'h4000, 1, 2'd1, 2'd2);
        vecs[15] = mk(1, 32'h0804, 0, 32'h0,    0, 2'd0, 2'd1);
        vecs[16] = mk(0, 32'h0,    1, 32'h0004, 1, 2'd1, 2'd0);
        vecs[17] = mk(1, 32'h0800, 0, 32'h0,    0, 2'd0, 2'd2);
        vecs[18] = mk(1, 32'h0804, 0, 32'h0,    0, 2'd0, 2'd1);
        vecs[19] = mk(1, 32'h0004, 0, 32'h0,    0, 2'd0, 2'd2);
        vecs[20] = mk(1, 32'h1000, 1, 32'h0800, 0, 2'd2, 2'd1);
        vecs[21] = mk(1, 32'h0004, 0, 32'h0,    0, 2'd0, 2'd1);

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
        check_reset_outputs("reset");
        measure_init("init0");

        for (int i = 0; i < NVEC; i++) begin
            check("run_pred_ready", {31'b0, pred_ready}, 32'd1);
            cycle(1'b0, vecs[i].pv, vecs[i].ppc, vecs[i].uv, vecs[i].upc,
                  vecs[i].ut, vecs[i].uc, vecs[i].exp_ctr);
        end

        // Reset in the middle of the sweep restarts it from entry 0.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 200; i++) idle();
        check("mid_init_busy", {31'b0, init_busy}, 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
        check_reset_outputs("reset_init");
        measure_init("init1");

        // Prediction accepted, then reset while another is presented: no pulse may follow the reset.
        cycle(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 2'd0, 2'd1);
        cycle(1'b1, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 2'd1, 2'd0);
        check_reset_outputs("reset_run");
        measure_init("init2");

        // Table re-initialised and last-write register cleared by reset.
        cycle(1'b0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 2'd0, 2'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0004, 1'b1, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, 32'h0800, 1'b0, 32'h0, 1'b0, 2'd0, 2'd1);
        idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bimodal_predictor.md
BIMODAL_PREDICTOR -- requirements
Module: bimodal_predictor

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 512, counter table depth (power of two).
REQ-002 SHALL have parameter CTR_WIDTH, default 2, saturating counter width.
REQ-003 SHALL have parameter PC_WIDTH, default 32, fetch PC width; IDX_W = log2(NUM_ENTRIES).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports pred_valid in 1 / pred_ready out 1 / pred_pc in PC_WIDTH: prediction request handshake and PC.
REQ-007 SHALL have ports pred_resp_valid out 1 / pred_taken out 1 / pred_ctr out CTR_WIDTH: prediction response.
REQ-008 SHALL have ports upd_valid in 1 / upd_ready out 1 / upd_pc in PC_WIDTH / upd_taken in 1 / upd_ctr in CTR_WIDTH: branch-resolution update; upd_ctr is the counter snapshot returned at prediction time.
REQ-009 SHALL have port init_busy  out  1  high while the table initialisation sweep runs.

Function
REQ-010 SHALL compute index = pc[IDX_W+1:2] XOR pc[2*IDX_W+1:IDX_W+2] for both prediction and update PCs.
REQ-011 SHALL implement a two-state FSM: INIT and RUN; rst forces INIT with sweep counter 0.
REQ-012 In INIT, SHALL write WEAK_NT (MSB 0, remaining bits 1; 2'b01 for CTR_WIDTH=2) to entry sweep counter each cycle, incrementing by 1.
REQ-013 SHALL move INIT -> RUN in the cycle after entry NUM_ENTRIES-1 is written; INIT lasts exactly NUM_ENTRIES cycles.
REQ-014 In INIT, SHALL hold init_busy=1, pred_ready=0, upd_ready=0; in RUN, init_busy=0, pred_ready=1, upd_ready=1.
REQ-015 A prediction is accepted when pred_valid && pred_ready; pred_resp_valid SHALL pulse high exactly one cycle later, for one cycle per accepted request.
REQ-016 pred_ctr SHALL be the table entry for the accepted index; pred_taken SHALL equal pred_ctr MSB.
REQ-017 If an accepted update writes the same index in the same cycle as an accepted prediction, the response SHALL carry the newly written value (write-to-read bypass).
REQ-018 An accepted update SHALL compute new = min(base+1, 2^CTR_WIDTH-1) if upd_taken, else max(base-1, 0), and write it in the same cycle.
REQ-019 base SHALL be upd_ctr, except when the last-write register is valid and holds the same index, in which case base SHALL be the last-write value.
REQ-020 The last-write register (valid, index, value) SHALL capture every update write, SHALL be cleared by rst, and SHALL NOT be loaded by INIT writes.
REQ-021 Back-to-back predictions and updates SHALL sustain one of each per cycle with no stall in RUN.
REQ-022 Read latency from table SHALL be exactly one cycle; no combinational path from pred_pc to pred_ctr.

Reset
REQ-023 On rst: pred_resp_valid=0, pred_taken=0, pred_ctr=0, init_busy=1, pred_ready=0, upd_ready=0, last-write valid=0.
REQ-024 rst asserted in INIT SHALL restart the sweep at entry 0; rst in RUN SHALL drop any in-flight response and re-enter INIT.

Structure
REQ-025 A shared package SHALL hold CTR_WIDTH default, WEAK_NT constant, FSM state enum, and the index hash function.
REQ-026 The table SHALL be one instance of dual_port_ram (data_width=CTR_WIDTH, num_entries=NUM_ENTRIES); write port muxed between INIT sweep and update path.
REQ-027 Counter saturation logic SHALL be a function in the package, not a separate sub-module.

Verification
REQ-028 Reset then idle: init_busy=1 for exactly 512 cycles, then 0; prediction for pc=0x1000 returns pred_ctr=2'b01, pred_taken=0 one cycle after acceptance.
REQ-029 Saturation: four updates taken, pc=0x2000, upd_ctr=3 -> entry stays 3; four not-taken updates with upd_ctr=0 -> entry stays 0.
REQ-030 Stale snapshot: two consecutive updates pc=0x3000, taken, both upd_ctr=1 -> entry ends at 3, not 2.
REQ-031 Bypass: update pc=0x4000 taken upd_ctr=1 and prediction pc=0x4000 in same cycle -> response pred_ctr=2, pred_taken=1.
REQ-032 Reset mid-INIT at cycle 200 and mid-RUN with prediction in flight -> sweep restarts, full 512-cycle init_busy, no pred_resp_valid pulse emitted.
REQ-033 Aliasing: pc=0x0004 and pc=0x0804 hash to different indices; pc pairs with equal hash share the counter (update one, predict other reflects it).
